// File: rtl/iter_integer_linear_calc.sv
// Iterative y = m*x + b (mod 2^WIDTH): shift-and-add, one multiplier bit per clock.
// ITER_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module iter_integer_linear_calc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mult;
    logic [CW-1:0]    cnt;

    // Remaining multiplier after this edge's shift; zero means no further
    // partial products can change acc.
    logic [WIDTH-1:0] mult_nxt;
    assign mult_nxt = mult >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            cnt   <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr) begin
                        acc   <= b;
                        mcand <= x;
                        mult  <= m;
                        cnt   <= '0;
`ifdef ITER_EARLY_TERM_EN
                        state <= (m == '0) ? DONE : RUN;
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (mult[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mult  <= mult_nxt;
                    cnt   <= cnt + 1'b1;
`ifdef ITER_EARLY_TERM_EN
                    if (mult_nxt == '0 || cnt == LAST)
                        state <= DONE;
`else
                    if (cnt == LAST)
                        state <= DONE;
`endif
                end
                DONE: begin
                    y     <= acc;
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_integer_linear_calc.sv
// Scoreboard bench for iter_integer_linear_calc: issued ops push expected (y, edge) pairs,
// a monitor pops on every valid pulse and checks value and timing.
module tb_iter_integer_linear_calc;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] y;
        int               at;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr  = 1'b0;
    logic [WIDTH-1:0] m = '0, x = '0, b = '0;
    logic [WIDTH-1:0] y;
    logic             valid;

    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_y = '0;
    exp_t             q[$];

    iter_integer_linear_calc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .wr(wr), .m(m), .x(x), .b(b), .y(y), .valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] model_y(input logic [WIDTH-1:0] mm, xx, bb);
        longint unsigned p;
        p = longint'(mm) * longint'(xx) + longint'(bb);
        return p[WIDTH-1:0];
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] mm);
`ifdef ITER_EARLY_TERM_EN
        int k = 0;
        for (int i = 0; i < WIDTH; i++)
            if (mm[i]) k = i + 1;
        return k + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    // Monitor: sample 2 time units after every rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            checks++;
            if (y !== '0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_state y=%0h valid=%b required y=0 valid=0", y, valid);
            end
        end else if (valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid y=%0h at edge %0d, no result pending", y, cyc);
            end else begin
                e = q.pop_front();
                if (y !== e.y || cyc != e.at) begin
                    errors++;
                    $display("FAIL result y=%0h edge=%0d required y=%0h edge=%0d", y, cyc, e.y, e.at);
                end
                last_y = e.y;
            end
        end else begin
            checks++;
            if (y !== last_y || valid !== 1'b0) begin
                errors++;
                $display("FAIL hold y=%0h valid=%b required y=%0h valid=0", y, valid, last_y);
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] mm, xx, bb);
        exp_t e;
        @(negedge clk);
        m = mm; x = xx; b = bb; wr = 1'b1;
        @(posedge clk);
        #1;
        e.y  = model_y(mm, xx, bb);
        e.at = cyc + model_lat(mm);
        q.push_back(e);
        wr = 1'b0;
        m = $urandom; x = $urandom; b = $urandom;
    endtask

    // Pulse wr without expecting a result (DUT is busy).
    task automatic poke(input logic [WIDTH-1:0] mm, xx, bb);
        @(negedge clk);
        m = mm; x = xx; b = bb; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout pending=%0d required 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        last_y = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        issue(32'd11, 32'd16, 32'd10);          // 186
        wait_done();
        issue(32'd7, 32'd12, 32'd10);           // 94, y holds 186 until then
        wait_done();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        wait_done();
        issue(32'd1, 32'd1, 32'hFFFF_FFFF);
        wait_done();
        issue(32'd0, 32'd123, 32'd55);
        wait_done();

        issue(32'd3, 32'd5, 32'd1);             // 16; wr during RUN ignored
        poke(32'd2, 32'd2, 32'd0);
        wait_done();

        issue(32'hFFFF_0000, 32'd9, 32'd3);     // reset aborts mid-RUN
        repeat (2) @(negedge clk);
        do_reset(3);
        repeat (2) @(negedge clk);
        issue(32'd4, 32'd5, 32'd6);             // 26
        wait_done();

        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] rm;
            rm = $urandom;
            if (i % 3 == 0) rm = rm >> $urandom_range(0, WIDTH - 1);
            issue(rm, $urandom, $urandom);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_integer_linear_calc.md
Name: iter_integer_linear_calc

Overview:
- Evaluates y = m*x + b on unsigned integers, truncated to WIDTH bits, using an iterative shift-and-add multiplier that retires one multiplier bit per clock.
- Small, low-area arithmetic helper for calibration and linear-scaling paths where throughput is not critical.
- A one-cycle write strobe launches a calculation. A one-cycle valid pulse marks the new result.

Parameters:
- WIDTH, 32, width of the m, x, b and y operands. The default build iteration count equals WIDTH.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  start strobe, sampled on the rising edge of clk.
- m  in  WIDTH  slope (multiplier), unsigned.
- x  in  WIDTH  input value (multiplicand), unsigned.
- b  in  WIDTH  offset, unsigned.
- y  out  WIDTH  registered result, m*x+b mod 2^WIDTH.
- valid  out  1  one-cycle pulse when y is updated.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, y=0, valid=0, all internal registers cleared. Reset is released synchronously into IDLE.
- States: IDLE, RUN, DONE.
- IDLE, wr=1 at edge N:
  - capture acc<=b, mcand<=x, mult<=m, cnt<=0.
  - go to RUN.
  - Inputs are sampled only at this edge; later changes to m, x or b have no effect.
- RUN, per edge:
  - if mult[0], acc<=acc+mcand (WIDTH bits, carry discarded).
  - mcand<=mcand<<1; mult<=mult>>1; cnt<=cnt+1.
  - After WIDTH iterations (edges N+1..N+WIDTH), go to DONE.
- DONE, edge N+WIDTH+1: y<=acc, valid<=1, return to IDLE.
- valid: high for exactly one clock and low at every other time.
- Latency: y and valid update at edge N+WIDTH+1, i.e. edge N+33 for the default build.
- y holds its last result until the next DONE or reset.
- wr in RUN or DONE: ignored (no queuing, no restart). A new calculation is accepted from the first IDLE cycle onward, so back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic: purely unsigned, modulo 2^WIDTH. Overflow of the product or of the sum wraps silently.
- m=0: result is b after the normal latency.
- Reset mid-calculation: aborts immediately; y=0, valid=0, no result produced.

Optional Feature:
- Macro: ITER_EARLY_TERM_EN.
- Defined:
  - RUN exits as soon as the remaining multiplier is zero. At capture, if m==0, go directly to DONE.
  - Iteration count k = bit length of m (0 for m=0); result at edge N+k+1.
  - Example: m=11 gives k=4 and a result at N+5.
  - Results are identical to the default build; only the latency differs.
- Undefined: fixed WIDTH iterations, deterministic latency WIDTH+2 edges from wr to next accept.

Test Plan:
- Reset held 10 cycles -> y=0, valid=0 throughout, including after release with wr=0.
- b=10, x=16, m=11, wr pulse at edge N -> y=186 (0xBA), valid pulse only at N+33 (N+5 with ITER_EARLY_TERM_EN).
- After that, b=10, x=12, m=7, wr pulse -> y=94. y holds 186 until the new valid pulse.
- Wrap: m=x=0xFFFFFFFF, b=0 -> y=1. Separately, m=1, x=1, b=0xFFFFFFFF -> y=0. m=0, x=123, b=55 -> y=55.
- wr re-asserted with m=2, x=2, b=0 during RUN of (m=3, x=5, b=1) -> only y=16 produced, a single valid pulse, no second result.
- rst asserted mid-RUN, then a new wr with m=4, x=5, b=6 -> no valid from the aborted operation, y=0 during reset, then y=26 with a normal-latency valid pulse.
